tt_mux_ctrl: RTL
================

# tt_mux_ctrl

Selection and enable sequencer for the user-design multiplexer spine. It takes three asynchronous control pads (select-reset, select-increment, enable) and maintains a design-address counter. It then drives the spine address plus the `ena`/`rst_n` pair seen by the selected user module. Switching between designs always follows a fixed sequence: disable, guard interval, held reset, run. No user module ever sees an address change while enabled or running out of reset.

## Interface
- `ADDR_W`, 10: spine address width.
- `MAX_ADDR`, 1023: highest valid address; increment wraps to 0 after it.
- `GUARD_CYCLES`, 4: cycles with `spine_ena`=0 after a new address is driven (≥1).
- `RST_CYCLES`, 16: cycles with `spine_ena`=1 and `user_rst_n`=0 before run (≥1).

- `clk`  in  1  single system clock.
- `rst`  in  1  synchronous, active-high reset.
- `ctrl_sel_rst_n`  in  1  async pad; low clears the select counter.
- `ctrl_sel_inc`  in  1  async pad; each rising edge increments the select counter.
- `ctrl_ena`  in  1  async pad; level request to run the selected design.
- `spine_addr`  out  ADDR_W  address driven onto the mux spine.
- `spine_ena`  out  1  enable to the addressed user module (its `ena`).
- `user_rst_n`  out  1  active-low reset to the addressed user module.
- `busy`  out  1  high in SWITCH or RESET.

## Operation
- Each pad passes through a 2-flop synchronizer.
  - Reset values: `sel_rst_n` 1, `inc` 1, `ena` 0.
  - The `inc` edge detector keeps a previous-value register that resets to 1, so an `inc` held high through reset is not counted.
- `sel_cnt` (ADDR_W bits) updates in every state:
  - Synced `sel_rst_n`=0: `sel_cnt` is set to 0. This has priority over a simultaneous increment edge.
  - Else, on a synced `inc` rising edge: `sel_cnt` increments, wrapping from MAX_ADDR to 0.
- `spine_addr` loads `sel_cnt` only on entry to SWITCH. At any other time it holds its value.
- FSM states:
  - IDLE: ena=0, rst_n=0. Goes to SWITCH when `ena_s`=1.
  - SWITCH: ena=0, rst_n=0. Counts GUARD_CYCLES, then goes to RESET. Goes to IDLE when `ena_s`=0.
  - RESET: ena=1, rst_n=0. Counts RST_CYCLES, then goes to RUN. Goes to IDLE when `ena_s`=0.
  - RUN: ena=1, rst_n=1. Goes to IDLE when `ena_s`=0. Goes to SWITCH (reloading `spine_addr`) when `sel_cnt` ≠ `spine_addr`.
- Priority in every state: `ena_s`=0 beats everything else, and the FSM goes to IDLE.
- Select changes during SWITCH or RESET do not restart the sequence. The mismatch is handled on arrival in RUN, which immediately re-enters SWITCH.
- One shared down-counter covers both SWITCH and RESET. It is sized for max(GUARD_CYCLES, RST_CYCLES).

## Timing
- Reset values: state IDLE, `sel_cnt`=0, `spine_addr`=0, `spine_ena`=0, `user_rst_n`=0, `busy`=0.
- All outputs are registered.
- Pad latency: a pad transition set up before edge k is visible to the FSM and counter logic after edge k+1. `sel_cnt` and FSM state update at edge k+2.
- Sequence after entering SWITCH at edge t:
  - `spine_addr` is valid from t.
  - `spine_ena` rises at t+GUARD_CYCLES.
  - `user_rst_n` rises at t+GUARD_CYCLES+RST_CYCLES.
- On the transition to IDLE or SWITCH, `spine_ena` and `user_rst_n` fall on the same edge that changes the state.
- `spine_addr` never changes in the same cycle that `spine_ena`=1.
- Asserting `rst` mid-sequence returns the block to IDLE on the next edge with all reset values. A pending increment edge is discarded.
- Minimum pad pulse for a guaranteed count: 2 `clk` periods high and 2 low.

## Structure
- Shared package `tt_mux_ctrl_pkg` holds:
  - FSM state encoding localparams: IDLE=0, SWITCH=1, RESET=2, RUN=3 (2-bit).
  - Default parameter constants.
- One sub-module, `tt_mux_ctrl_sync`: a 2-flop synchronizer with a `RST_VAL` parameter. It is instantiated three times.
- Edge detection, counter and FSM live in `tt_mux_ctrl`.

## Test plan
- Reset, then `ctrl_ena`=1 with `sel_cnt`=0 and defaults:
  - `spine_addr`=0.
  - `spine_ena` rises 4 cycles after SWITCH entry.
  - `user_rst_n` rises 16 cycles later.
  - `busy` is high for exactly 20 cycles.
- 5 `inc` pulses while in RUN at address 0:
  - The FSM re-enters SWITCH and `spine_ena` drops.
  - `spine_addr`=5 with `spine_ena`=0.
  - The full guard/reset sequence reruns.
- `MAX_ADDR`=3, then 4 `inc` pulses from 0 → `sel_cnt` reads 0 (wrap).
  - The `sel_rst_n`-low and `inc`-edge collision case → `sel_cnt`=0.
- `ctrl_ena` dropped during RESET (cycle 8 of 16) → IDLE next edge: `spine_ena`=0 and `user_rst_n` stays 0.
  - Re-assert → the sequence restarts from SWITCH with the full guard interval.
- `ctrl_sel_inc` held high across `rst` → no increment after release.
- `rst` asserted in RUN → all outputs 0 and `sel_cnt`=0 on the next edge.
- Random pad activity with asserts:
  - `spine_addr` is stable whenever `spine_ena`=1.
  - `user_rst_n`=1 implies `spine_ena`=1.
  - `busy` is high only in SWITCH/RESET.

Source files
------------

// File: rtl/tt_mux_ctrl_pkg.sv
// Shared constants and FSM state encoding for the mux-spine selection sequencer.
package tt_mux_ctrl_pkg;

  localparam int unsigned DefAddrW       = 10;
  localparam int unsigned DefMaxAddr     = 1023;
  localparam int unsigned DefGuardCycles = 4;
  localparam int unsigned DefRstCycles   = 16;

  localparam logic [1:0] StateIdle   = 2'd0;
  localparam logic [1:0] StateSwitch = 2'd1;
  localparam logic [1:0] StateReset  = 2'd2;
  localparam logic [1:0] StateRun    = 2'd3;

  typedef enum logic [1:0] {
    StIdle   = StateIdle,
    StSwitch = StateSwitch,
    StReset  = StateReset,
    StRun    = StateRun
  } state_e;

endpackage

// File: rtl/tt_mux_ctrl_sync.sv
// Two-flop synchronizer for an asynchronous control pad, with a configurable reset value.
module tt_mux_ctrl_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      q      <= RST_VAL;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/tt_mux_ctrl.sv
// Design-select counter and disable/guard/reset/run sequencer driving the mux spine.
module tt_mux_ctrl
  import tt_mux_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W       = DefAddrW,
  parameter int unsigned MAX_ADDR     = DefMaxAddr,
  parameter int unsigned GUARD_CYCLES = DefGuardCycles,
  parameter int unsigned RST_CYCLES   = DefRstCycles
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_sel_rst_n,
  input  logic              ctrl_sel_inc,
  input  logic              ctrl_ena,
  output logic [ADDR_W-1:0] spine_addr,
  output logic              spine_ena,
  output logic              user_rst_n,
  output logic              busy
);

  localparam int unsigned CntMax = (GUARD_CYCLES > RST_CYCLES) ? GUARD_CYCLES : RST_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [ADDR_W-1:0] MaxAddr   = ADDR_W'(MAX_ADDR);
  localparam logic [CntW-1:0]   GuardLoad = CntW'(GUARD_CYCLES - 1);
  localparam logic [CntW-1:0]   RstLoad   = CntW'(RST_CYCLES - 1);

  logic sel_rst_n_s, inc_s, ena_s;

  tt_mux_ctrl_sync #(.RST_VAL(1'b1)) u_sync_sel_rst_n (
    .clk (clk),
    .rst (rst),
    .d   (ctrl_sel_rst_n),
    .q   (sel_rst_n_s)
  );

  tt_mux_ctrl_sync #(.RST_VAL(1'b1)) u_sync_inc (
    .clk (clk),
    .rst (rst),
    .d   (ctrl_sel_inc),
    .q   (inc_s)
  );

  tt_mux_ctrl_sync #(.RST_VAL(1'b0)) u_sync_ena (
    .clk (clk),
    .rst (rst),
    .d   (ctrl_ena),
    .q   (ena_s)
  );

  logic              inc_prev_q;
  logic              inc_rise;
  logic [ADDR_W-1:0] sel_cnt_q, sel_cnt_d;
  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              load_addr;

  assign inc_rise = inc_s & ~inc_prev_q;

  // Select clear wins over a coincident increment edge.
  always_comb begin
    sel_cnt_d = sel_cnt_q;
    if (!sel_rst_n_s) begin
      sel_cnt_d = '0;
    end else if (inc_rise) begin
      sel_cnt_d = (sel_cnt_q == MaxAddr) ? '0 : sel_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_addr = 1'b0;
    if (!ena_s) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          state_d   = StSwitch;
          cnt_d     = GuardLoad;
          load_addr = 1'b1;
        end
        StSwitch: begin
          if (cnt_q == '0) begin
            state_d = StReset;
            cnt_d   = RstLoad;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StReset: begin
          if (cnt_q == '0) begin
            state_d = StRun;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StRun: begin
          // Select changes made mid-sequence are picked up here.
          if (sel_cnt_q != spine_addr) begin
            state_d   = StSwitch;
            cnt_d     = GuardLoad;
            load_addr = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      sel_cnt_q  <= '0;
      inc_prev_q <= 1'b1;
      spine_addr <= '0;
      spine_ena  <= 1'b0;
      user_rst_n <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_cnt_q  <= sel_cnt_d;
      inc_prev_q <= inc_s;
      if (load_addr) begin
        spine_addr <= sel_cnt_q;
      end
      spine_ena  <= (state_d == StReset) || (state_d == StRun);
      user_rst_n <= (state_d == StRun);
      busy       <= (state_d == StSwitch) || (state_d == StReset);
    end
  end

endmodule
